md_iter_unit: RTL and testbench
===============================

MD_ITER_UNIT -- requirements
Module: md_iter_unit

Interface
REQ-001 The unit SHALL have parameter WIDTH, default 32, giving the operand width and the width of each of HI and LO; legal values are even and at least 8.
REQ-002 The unit SHALL have parameter DIV0_LO, default all ones, giving the LO value written on divide-by-zero.
REQ-003 The unit SHALL have port clk, input, 1 bit: the only clock; all state changes on its rising edge.
REQ-004 The unit SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The unit SHALL have port start, input, 1 bit: request an operation, sampled only in IDLE.
REQ-006 The unit SHALL have port func, input, 3 bits: operation code; 000 none, 001 MUL, 010 DIV, 011 MTHI, 100 MTLO; other codes behave as none.
REQ-007 The unit SHALL have port is_sign, input, 1 bit: 1 means signed two's-complement MUL/DIV, 0 means unsigned.
REQ-008 The unit SHALL have port a, input, WIDTH bits: multiplicand, dividend, or MTHI/MTLO data (forwarded rs value).
REQ-009 The unit SHALL have port b, input, WIDTH bits: multiplier or divisor (forwarded rt value).
REQ-010 The unit SHALL have port cancel, input, 1 bit: EX flush; aborts any in-flight operation.
REQ-011 The unit SHALL have port busy, output, 1 bit: operation in flight; the pipeline stalls MFHI/MFLO and new MD ops while it is high.
REQ-012 The unit SHALL have port done, output, 1 bit: one-cycle pulse in the cycle after HI/LO update from MUL/DIV.
REQ-013 The unit SHALL have port hi, output, WIDTH bits: registered HI.
REQ-014 The unit SHALL have port lo, output, WIDTH bits: registered LO.

Function
REQ-015 The state machine SHALL have states IDLE, CALC, FIX; busy SHALL be 1 exactly in CALC and FIX.
REQ-016 In IDLE with start=1, cancel=0 and func MUL or DIV, the unit SHALL latch magnitude operands (absolute values when is_sign=1), result-sign flags and the op, and move to CALC.
REQ-017 CALC SHALL last exactly WIDTH cycles: MUL does one shift-add step per cycle, DIV does one restoring shift-subtract step per cycle, using a 2*WIDTH-bit working register.
REQ-018 FIX SHALL last one cycle; at its end it SHALL apply sign correction and write HI/LO, then return to IDLE; done SHALL pulse in the following cycle.
REQ-019 The latency from the start-accept edge to the HI/LO-update edge SHALL be WIDTH+1 cycles (33 for WIDTH=32).
REQ-020 MUL SHALL write {HI,LO} = the full 2*WIDTH-bit product, negated when is_sign=1 and the operand signs differ.
REQ-021 DIV SHALL write LO = quotient truncated toward zero and HI = remainder carrying the sign of the dividend (when signed).
REQ-022 DIV with b=0 SHALL skip CALC, enter FIX directly, and write HI=a and LO=DIV0_LO.
REQ-023 Signed DIV of the most-negative value by -1 SHALL write LO=most-negative value (wrap) and HI=0.
REQ-024 MTHI/MTLO in IDLE with start=1 SHALL write a to HI/LO at that edge, with no busy and no done.
REQ-025 start while busy SHALL be ignored.
REQ-026 cancel=1 in any state SHALL return the unit to IDLE at the next edge with HI/LO unchanged and no done; if cancel and start are both high, cancel wins.
REQ-027 Outputs hi and lo SHALL change only at an MTHI/MTLO write, at the end of FIX, or at reset.

Reset
REQ-028 rst low SHALL asynchronously force state IDLE, busy=0, done=0, hi=0, lo=0 and clear the working registers.
REQ-029 A reset asserted mid-operation SHALL discard the operation, and no done SHALL follow the reset release.

Structure
REQ-030 The func encoding (md_func_e) and the state enum (md_state_e) SHALL live in shared package md_pkg.
REQ-031 One sub-module SHALL be natural: md_sign_fix, a combinational conditional-negate helper used for operand magnitude and result correction.

Verification (WIDTH=32)
REQ-032 MUL, unsigned, a=b=0xFFFFFFFF -> after 33 cycles HI=0xFFFFFFFE, LO=0x00000001, done pulses once.
REQ-033 MUL, signed, a=-3, b=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1.
REQ-034 DIV, signed, a=-7, b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV, signed, a=0x80000000, b=-1 -> LO=0x80000000, HI=0.
REQ-035 DIV, unsigned, a=0x1234, b=0 -> HI=0x1234, LO=0xFFFFFFFF, with busy high for exactly 1 cycle.
REQ-036 Preload HI=0xAA via MTHI, start MUL, assert cancel in CALC cycle 10 -> busy drops next edge, HI stays 0xAA, no done.
REQ-037 Start DIV, pull rst low in CALC cycle 5 -> outputs 0 immediately, and after release start is accepted normally.

Source files
------------

// File: rtl/md_pkg.sv
// md_pkg: types shared by the iterative multiply/divide unit.
//   md_func_e  - operation code presented on func
//   md_state_e - sequencer states of md_iter_unit
package md_pkg;

   typedef enum logic [2:0] {
      FUNC_NONE = 3'b000,
      FUNC_MUL  = 3'b001,
      FUNC_DIV  = 3'b010,
      FUNC_MTHI = 3'b011,
      FUNC_MTLO = 3'b100
   } md_func_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } md_state_e;

endpackage

// File: rtl/md_sign_fix.sv
// md_sign_fix: combinational conditional two's-complement negate.
//   i_val - value to correct
//   i_neg - 1 to negate i_val
//   o_val - i_neg ? -i_val : i_val
module md_sign_fix #(
   parameter int W = 32
) (
   input  logic [W-1:0] i_val,
   input  logic         i_neg,
   output logic [W-1:0] o_val
);

   assign o_val = i_neg ? ((~i_val) + {{(W-1){1'b0}}, 1'b1}) : i_val;

endmodule

// File: rtl/md_iter_unit.sv
// md_iter_unit: iterative multiply/divide unit with HI/LO result registers.
//   clk     - clock, rising edge
//   rst     - asynchronous active-low reset
//   start   - operation request, sampled in IDLE only
//   func    - md_func_e operation code
//   is_sign - signed (1) / unsigned (0) MUL and DIV
//   a, b    - operands (a also carries MTHI/MTLO data)
//   cancel  - flush, aborts any operation without touching HI/LO
//   busy    - high while CALC or FIX
//   done    - one-cycle pulse after HI/LO update from MUL/DIV
//   hi, lo  - result registers
//
// state | meaning
// IDLE  | waiting; accepts MUL/DIV, performs MTHI/MTLO writes
// CALC  | WIDTH shift-add (MUL) or restoring shift-subtract (DIV) steps
// FIX   | sign correction, HI/LO write, back to IDLE
module md_iter_unit
   import md_pkg::*;
#(
   parameter int               WIDTH   = 32,
   parameter logic [WIDTH-1:0] DIV0_LO = '1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       func,
   input  logic             is_sign,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cancel,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH);

   md_state_e          r_state;
   md_state_e          w_state_nxt;
   logic [CW-1:0]      r_cnt;
   logic [2*WIDTH-1:0] r_acc;
   logic [WIDTH-1:0]   r_opb;
   logic [WIDTH-1:0]   r_a_raw;
   logic               r_is_div;
   logic               r_div0;
   logic               r_neg_q;
   logic               r_neg_r;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic               r_done;

   logic               w_accept;
   logic               w_fix_wr;
   logic               w_mt_hi;
   logic               w_mt_lo;
   logic               w_is_div_req;
   logic               w_b_zero;
   logic               w_neg_a;
   logic               w_neg_b;
   logic [WIDTH-1:0]   w_abs_a;
   logic [WIDTH-1:0]   w_abs_b;
   logic [WIDTH:0]     w_mul_sum;
   logic [2*WIDTH-1:0] w_mul_step;
   logic [WIDTH:0]     w_div_top;
   logic [WIDTH:0]     w_div_diff;
   logic [2*WIDTH-1:0] w_div_step;
   logic [2*WIDTH-1:0] w_prod_fix;
   logic [WIDTH-1:0]   w_quo_fix;
   logic [WIDTH-1:0]   w_rem_fix;

   assign w_is_div_req = (func == FUNC_DIV);
   assign w_b_zero     = (b == '0);
   assign w_neg_a      = is_sign & a[WIDTH-1];
   assign w_neg_b      = is_sign & b[WIDTH-1];

   md_sign_fix #(.W(WIDTH))   u_abs_a   (.i_val(a),                     .i_neg(w_neg_a), .o_val(w_abs_a));
   md_sign_fix #(.W(WIDTH))   u_abs_b   (.i_val(b),                     .i_neg(w_neg_b), .o_val(w_abs_b));
   md_sign_fix #(.W(2*WIDTH)) u_fix_prd (.i_val(r_acc),                 .i_neg(r_neg_q), .o_val(w_prod_fix));
   md_sign_fix #(.W(WIDTH))   u_fix_quo (.i_val(r_acc[WIDTH-1:0]),       .i_neg(r_neg_q), .o_val(w_quo_fix));
   md_sign_fix #(.W(WIDTH))   u_fix_rem (.i_val(r_acc[2*WIDTH-1:WIDTH]), .i_neg(r_neg_r), .o_val(w_rem_fix));

   // MUL: accumulator upper half gains the multiplicand when the current
   // multiplier bit (acc LSB) is set; carry rides in as the new MSB on shift.
   assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opb};
   assign w_mul_step = r_acc[0] ? {w_mul_sum, r_acc[WIDTH-1:1]}
                                : {1'b0, r_acc[2*WIDTH-1:1]};

   // DIV: the partial remainder shifted left needs WIDTH+1 bits; the MSB of
   // the difference is the borrow that decides restore vs. keep.
   assign w_div_top  = r_acc[2*WIDTH-1:WIDTH-1];
   assign w_div_diff = w_div_top - {1'b0, r_opb};
   assign w_div_step = w_div_diff[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                         : {w_div_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= IDLE;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_fix_wr    = 1'b0;
      w_mt_hi     = 1'b0;
      w_mt_lo     = 1'b0;
      if (cancel) begin
         w_state_nxt = IDLE;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  case (func)
                     FUNC_MUL, FUNC_DIV: begin
                        w_accept    = 1'b1;
                        w_state_nxt = (w_is_div_req && w_b_zero) ? FIX : CALC;
                     end
                     FUNC_MTHI: w_mt_hi = 1'b1;
                     FUNC_MTLO: w_mt_lo = 1'b1;
                     default: ;
                  endcase
               end
            end
            CALC: if (r_cnt == '0) w_state_nxt = FIX;
            FIX: begin
               w_fix_wr    = 1'b1;
               w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt    <= '0;
         r_acc    <= '0;
         r_opb    <= '0;
         r_a_raw  <= '0;
         r_is_div <= 1'b0;
         r_div0   <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_done   <= 1'b0;
      end else begin
         r_done <= w_fix_wr;
         if (w_accept) begin
            r_acc    <= {{WIDTH{1'b0}}, w_abs_a};
            r_opb    <= w_abs_b;
            r_a_raw  <= a;
            r_is_div <= w_is_div_req;
            r_div0   <= w_is_div_req && w_b_zero;
            r_neg_q  <= w_neg_a ^ w_neg_b;
            r_neg_r  <= w_neg_a;
            r_cnt    <= CW'(WIDTH - 1);
         end else if (r_state == CALC && !cancel) begin
            r_acc <= r_is_div ? w_div_step : w_mul_step;
            r_cnt <= r_cnt - 1'b1;
         end

         if (w_fix_wr) begin
            if (r_div0) begin
               r_hi <= r_a_raw;
               r_lo <= DIV0_LO;
            end else if (r_is_div) begin
               r_hi <= w_rem_fix;
               r_lo <= w_quo_fix;
            end else begin
               {r_hi, r_lo} <= w_prod_fix;
            end
         end else begin
            if (w_mt_hi) r_hi <= a;
            if (w_mt_lo) r_lo <= a;
         end
      end
   end

   assign busy = (r_state == CALC) || (r_state == FIX);
   assign done = r_done;
   assign hi   = r_hi;
   assign lo   = r_lo;

endmodule

// File: tb/tb_md_iter_unit.sv
module tb_md_iter_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  func = 3'b000;
   logic        is_sign = 1'b0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        cancel = 1'b0;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int checks   = 0;
   int failures = 0;

   md_iter_unit dut (
      .clk(clk), .rst(rst), .start(start), .func(func), .is_sign(is_sign),
      .a(a), .b(b), .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_op(input logic [2:0] f, input logic s, input logic [31:0] va, input logic [31:0] vb);
      func = f; is_sign = s; a = va; b = vb; start = 1'b1;
      tick();
      start = 1'b0; func = 3'b000;
   endtask

   task automatic run_until_done(output int n);
      n = 0;
      while (done !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #3;
      checks++; if ({busy, done} !== 2'b00) begin failures++; $display("FAIL reset_ctl got=%b exp=00", {busy, done}); end
      checks++; if ({hi, lo} !== 64'h0) begin failures++; $display("FAIL reset_hilo got=%h exp=0", {hi, lo}); end
      tick(); tick();
      rst = 1'b1;
      tick();
   endtask

   task automatic test_mul_unsigned();
      int n;
      start_op(3'b001, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mul_u_busy got=%b exp=1", busy); end
      run_until_done(n);
      checks++; if (n !== 33) begin failures++; $display("FAIL mul_u_latency got=%0d exp=33", n); end
      checks++; if (hi !== 32'hFFFF_FFFE) begin failures++; $display("FAIL mul_u_hi got=%h exp=fffffffe", hi); end
      checks++; if (lo !== 32'h0000_0001) begin failures++; $display("FAIL mul_u_lo got=%h exp=00000001", lo); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mul_u_idle got=%b exp=0", busy); end
      tick();
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL mul_u_done_once got=%b exp=0", done); end
   endtask

   task automatic test_mul_signed();
      int n;
      start_op(3'b001, 1'b1, 32'hFFFF_FFFD, 32'd5);
      run_until_done(n);
      checks++; if (n !== 33) begin failures++; $display("FAIL mul_s_latency got=%0d exp=33", n); end
      checks++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFF1) begin failures++; $display("FAIL mul_s_result got=%h exp=fffffffffffffff1", {hi, lo}); end
      tick();
   endtask

   task automatic test_div_signed();
      int n;
      start_op(3'b010, 1'b1, 32'hFFFF_FFF9, 32'd2);
      run_until_done(n);
      checks++; if (n !== 33) begin failures++; $display("FAIL div_s_latency got=%0d exp=33", n); end
      checks++; if (lo !== 32'hFFFF_FFFD) begin failures++; $display("FAIL div_s_lo got=%h exp=fffffffd", lo); end
      checks++; if (hi !== 32'hFFFF_FFFF) begin failures++; $display("FAIL div_s_hi got=%h exp=ffffffff", hi); end
      tick();
      start_op(3'b010, 1'b1, 32'd7, 32'hFFFF_FFFE);
      run_until_done(n);
      checks++; if ({hi, lo} !== {32'd1, 32'hFFFF_FFFD}) begin failures++; $display("FAIL div_s_negdivisor got=%h exp=00000001fffffffd", {hi, lo}); end
      tick();
      start_op(3'b010, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
      run_until_done(n);
      checks++; if (lo !== 32'h8000_0000) begin failures++; $display("FAIL div_minneg_lo got=%h exp=80000000", lo); end
      checks++; if (hi !== 32'h0) begin failures++; $display("FAIL div_minneg_hi got=%h exp=0", hi); end
      tick();
   endtask

   task automatic test_div_zero();
      int n;
      start_op(3'b010, 1'b0, 32'h0000_1234, 32'h0);
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL div0_busy got=%b exp=1", busy); end
      tick();
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL div0_busy_1cyc got=%b exp=0", busy); end
      checks++; if (done !== 1'b1) begin failures++; $display("FAIL div0_done got=%b exp=1", done); end
      checks++; if ({hi, lo} !== {32'h0000_1234, 32'hFFFF_FFFF}) begin failures++; $display("FAIL div0_result got=%h exp=00001234ffffffff", {hi, lo}); end
      tick();
   endtask

   task automatic test_mt_and_cancel();
      int pulses;
      start_op(3'b011, 1'b0, 32'h0000_00AA, 32'h0);
      checks++; if (hi !== 32'h0000_00AA) begin failures++; $display("FAIL mthi_hi got=%h exp=000000aa", hi); end
      checks++; if ({busy, done} !== 2'b00) begin failures++; $display("FAIL mthi_ctl got=%b exp=00", {busy, done}); end
      start_op(3'b100, 1'b0, 32'h0000_0077, 32'h0);
      checks++; if (lo !== 32'h0000_0077) begin failures++; $display("FAIL mtlo_lo got=%h exp=00000077", lo); end
      // cancel beats a simultaneous MTLO
      cancel = 1'b1;
      start_op(3'b100, 1'b0, 32'h0000_0055, 32'h0);
      cancel = 1'b0;
      checks++; if (lo !== 32'h0000_0077) begin failures++; $display("FAIL cancel_vs_mtlo got=%h exp=00000077", lo); end
      start_op(3'b001, 1'b0, 32'd3, 32'd5);
      for (int i = 0; i < 9; i++) tick();
      cancel = 1'b1;
      tick();
      cancel = 1'b0;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL cancel_busy got=%b exp=0", busy); end
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         if (done === 1'b1) pulses++;
         tick();
      end
      checks++; if (pulses !== 0) begin failures++; $display("FAIL cancel_no_done got=%0d exp=0", pulses); end
      checks++; if ({hi, lo} !== {32'h0000_00AA, 32'h0000_0077}) begin failures++; $display("FAIL cancel_hilo got=%h exp=000000aa00000077", {hi, lo}); end
   endtask

   task automatic test_reset_mid();
      int n;
      int pulses;
      start_op(3'b010, 1'b0, 32'd100, 32'd7);
      for (int i = 0; i < 4; i++) tick();
      rst = 1'b0;
      #1;
      checks++; if ({busy, done, hi, lo} !== 66'h0) begin failures++; $display("FAIL reset_mid got=%h exp=0", {busy, done, hi, lo}); end
      tick(); tick();
      rst = 1'b1;
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         if (done === 1'b1 || busy === 1'b1) pulses++;
         tick();
      end
      checks++; if (pulses !== 0) begin failures++; $display("FAIL reset_mid_quiet got=%0d exp=0", pulses); end
      start_op(3'b010, 1'b0, 32'd100, 32'd7);
      run_until_done(n);
      checks++; if (n !== 33) begin failures++; $display("FAIL reset_after_latency got=%0d exp=33", n); end
      checks++; if ({hi, lo} !== {32'd2, 32'd14}) begin failures++; $display("FAIL reset_after_result got=%h exp=%h", {hi, lo}, {32'd2, 32'd14}); end
      tick();
   endtask

   task automatic test_back_to_back();
      int n;
      start_op(3'b001, 1'b0, 32'd6, 32'd7);
      // MTHI and a new MUL requested while busy must be ignored
      func = 3'b011; a = 32'h0000_0055; start = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      func = 3'b001; a = 32'd9; b = 32'd9;
      for (int i = 0; i < 5; i++) tick();
      start = 1'b0; func = 3'b000;
      run_until_done(n);
      checks++; if (n !== 23) begin failures++; $display("FAIL b2b_latency got=%0d exp=23", n); end
      checks++; if ({hi, lo} !== {32'd0, 32'd42}) begin failures++; $display("FAIL b2b_mul got=%h exp=%h", {hi, lo}, {32'd0, 32'd42}); end
      start_op(3'b010, 1'b0, 32'hFFFF_FFFF, 32'h0000_0010);
      run_until_done(n);
      checks++; if ({hi, lo} !== {32'h0000_000F, 32'h0FFF_FFFF}) begin failures++; $display("FAIL b2b_div got=%h exp=0000000f0fffffff", {hi, lo}); end
      tick();
   endtask

   initial begin
      test_reset();
      test_mul_unsigned();
      test_mul_signed();
      test_div_signed();
      test_div_zero();
      test_mt_and_cancel();
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
